// File: rtl/denoise_top_hls_dl_pkg.sv
// Shared types and helpers for the deadlock track unit.
// Holds the tracker FSM encoding and a constant clog2.
package denoise_top_hls_dl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_REPORT  = 2'd2
  } dl_state_e;

  function automatic int dl_clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/denoise_top_hls_dl_token_rr.sv
// Round-robin picker for the outgoing token channel.
// Searches from last_grant+1 with wrap; no request falls back to channel 0.
module denoise_top_hls_dl_token_rr
  import denoise_top_hls_dl_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? dl_clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic          found;
  logic [IW-1:0] cand;
  int            sum;

  always_comb begin
    grant     = N'(1);
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    sum       = 0;
    for (int off = 1; off <= N; off++) begin
      sum = int'(last_grant) + off;
      if (sum >= N) sum = sum - N;
      cand = IW'(sum);
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant     = N'(1) << cand;
        grant_idx = cand;
      end
    end
  end

endmodule

// File: rtl/denoise_top_hls_deadlock_track_unit.sv
// Per-process deadlock tracker: merges dependencies, confirms a
// persistent self-dependency, and forwards the report token.
module denoise_top_hls_deadlock_track_unit
  import denoise_top_hls_dl_pkg::*;
#(
  parameter int PROC_NUM     = 4,
  parameter int PROC_ID      = 0,
  parameter int IN_CHAN_NUM  = 2,
  parameter int OUT_CHAN_NUM = 3,
  parameter int DL_PERSIST   = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [OUT_CHAN_NUM-1:0]         proc_dep_vld_vec,
  input  logic [IN_CHAN_NUM-1:0]          in_chan_dep_vld_vec,
  input  logic [IN_CHAN_NUM*PROC_NUM-1:0] in_chan_dep_data_vec,
  input  logic [IN_CHAN_NUM-1:0]          token_in_vec,
  input  logic                            dl_detect_in,
  input  logic                            origin,
  input  logic                            token_clear,
  input  logic                            report_ack,
  output logic [OUT_CHAN_NUM-1:0]         out_chan_dep_vld_vec,
  output logic [PROC_NUM-1:0]             out_chan_dep_data,
  output logic [OUT_CHAN_NUM-1:0]         token_out_vec,
  output logic                            dl_detect_out,
  output logic [PROC_NUM-1:0]             dl_report_dep
);

  localparam int CW = dl_clog2(DL_PERSIST + 1);
  localparam int GW = (OUT_CHAN_NUM > 1) ? dl_clog2(OUT_CHAN_NUM) : 1;
  localparam logic [PROC_NUM-1:0] OWN_BIT = PROC_NUM'(1) << PROC_ID;
  localparam logic [CW-1:0] CNT_MAX  = CW'(DL_PERSIST);
  localparam logic [CW-1:0] CNT_LAST = CW'(DL_PERSIST - 1);
  localparam logic [GW-1:0] LG_RST   = GW'(OUT_CHAN_NUM - 1);

  logic [PROC_NUM-1:0]     dep_comb;
  logic [PROC_NUM-1:0]     dep;
  logic                    sel;
  logic                    blocked;
  logic                    hit;
  logic                    issue;
  logic [OUT_CHAN_NUM-1:0] rr_grant;
  logic [GW-1:0]           rr_idx;

  logic [PROC_NUM-1:0]     dep_reg_d, dep_reg_q;
  logic [CW-1:0]           cnt_d, cnt_q;
  dl_state_e               state_d, state_q;
  logic                    detect_d, detect_q;
  logic [PROC_NUM-1:0]     report_dep_d, report_dep_q;
  logic [OUT_CHAN_NUM-1:0] token_d, token_q;
  logic [GW-1:0]           last_grant_d, last_grant_q;

  always_comb begin
    dep_comb = '0;
    for (int i = 0; i < IN_CHAN_NUM; i++) begin
      if (in_chan_dep_vld_vec[i])
        dep_comb = dep_comb | in_chan_dep_data_vec[i*PROC_NUM +: PROC_NUM];
    end
  end

  // Once a deadlock is flagged globally, only token-bearing cycles refresh dep
  assign sel       = ~dl_detect_in | (|token_in_vec);
  assign dep       = sel ? dep_comb : dep_reg_q;
  assign blocked   = |proc_dep_vld_vec;
  assign hit       = sel & dep[PROC_ID] & blocked;
  assign dep_reg_d = blocked ? dep : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    if (hit)
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (hit)
          state_d = (DL_PERSIST == 1) ? ST_REPORT : ST_CONFIRM;
      end
      ST_CONFIRM: begin
        if (!hit)
          state_d = ST_IDLE;
        else if (cnt_q == CNT_LAST)
          state_d = ST_REPORT;
      end
      ST_REPORT: begin
        if (report_ack) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign detect_d = (state_d == ST_REPORT);
  assign report_dep_d =
    (detect_d && state_q != ST_REPORT) ? dep : report_dep_q;

  denoise_top_hls_dl_token_rr #(
    .N  (OUT_CHAN_NUM),
    .IW (GW)
  ) u_rr (
    .req        (proc_dep_vld_vec),
    .last_grant (last_grant_q),
    .grant      (rr_grant),
    .grant_idx  (rr_idx)
  );

  assign issue        = ((|token_in_vec) & ~token_clear) | origin;
  assign token_d      = issue ? rr_grant : '0;
  assign last_grant_d = issue ? rr_idx : last_grant_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      dep_reg_q    <= '0;
      cnt_q        <= '0;
      state_q      <= ST_IDLE;
      detect_q     <= 1'b0;
      report_dep_q <= '0;
      token_q      <= '0;
      last_grant_q <= LG_RST;
    end else begin
      dep_reg_q    <= dep_reg_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      detect_q     <= detect_d;
      report_dep_q <= report_dep_d;
      token_q      <= token_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_chan_dep_vld_vec = proc_dep_vld_vec;
  assign out_chan_dep_data    = dep_reg_q | OWN_BIT;
  assign token_out_vec        = token_q;
  assign dl_detect_out        = detect_q;
  assign dl_report_dep        = report_dep_q;

endmodule
